// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, frame constants and divider helper for the UART receiver
// Purpose: FSM state encoding, 8N1 frame constants and the baud-divider calculation
//          shared by uart_byte_receiver and uart_baud_tick.
// Ports:   none (package).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_e;

    localparam int UART_START_BITS = 1;
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_STOP_BITS  = 1;

    // Clocks per oversample tick, rounded to nearest; never below 1.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int den;
        int div;
        den = baud * oversample;
        div = (clk_freq + den / 2) / den;
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running divider producing the oversample tick
// Purpose: emits a one-clock o_tick every DIV clocks, independent of line activity.
// Ports:   clk    in  system clock
//          rst_n  in  asynchronous active-low reset
//          o_tick out one-clock oversample tick
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int               CNT_W = $clog2(DIV) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/uart_byte_receiver.sv
// rtl/uart_byte_receiver.sv - UART 8N1 byte receiver with majority-voted oversampling
// Purpose: synchronizes RxD, recovers one byte per frame, pulses ready on a good
//          stop bit or error on a low stop bit.
// Ports:   clk            in   system clock
//          rst_n          in   asynchronous active-low reset
//          RxD            in   serial line, idle high
//          RxD_data       out  last good byte (LSB = first data bit)
//          RxD_data_ready out  one-clock pulse, RxD_data just updated
//          RxD_data_error out  one-clock pulse, framing error
module uart_byte_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_data_error
);

    localparam int DIV  = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int PH_W = $clog2(OVERSAMPLE);

    // Phase value k marks the (k+1)-th tick since the start edge, so the three
    // samples land on ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
    localparam logic [PH_W-1:0] PH_S0   = PH_W'(OVERSAMPLE / 2 - 2);
    localparam logic [PH_W-1:0] PH_S1   = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0] PH_VOTE = PH_W'(OVERSAMPLE / 2);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
    localparam logic [2:0]      LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            w_rx;
    logic            w_tick;
    logic [PH_W-1:0] r_phase;
    logic [1:0]      r_samp;
    logic            w_vote;
    logic            w_vote_tick;
    logic            w_wrap;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_ready;
    logic            r_error;
    logic            w_ready_nxt;
    logic            w_error_nxt;
    uart_state_e     r_state;
    uart_state_e     w_state_nxt;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick)
    );

    assign w_rx        = r_sync2;
    assign w_vote_tick = w_tick && (r_phase == PH_VOTE);
    assign w_wrap      = w_tick && (r_phase == PH_LAST);
    // The third sample is the live synchronized value on the vote tick.
    assign w_vote      = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx) | (r_samp[1] & w_rx);

    always_comb begin
        w_state_nxt = r_state;
        w_ready_nxt = 1'b0;
        w_error_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx) w_state_nxt = START;
            end
            START: begin
                // A high vote at mid start bit means the falling edge was a glitch.
                if (w_vote_tick && w_vote) w_state_nxt = IDLE;
                else if (w_wrap)           w_state_nxt = DATA;
            end
            DATA: begin
                if (w_wrap && (r_bit_idx == LAST_BIT)) w_state_nxt = STOP;
            end
            STOP: begin
                // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
                if (w_vote_tick) begin
                    if (w_vote) begin
                        w_ready_nxt = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // A held-low line (break) must not be taken as a stream of start bits.
                if (w_rx) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_phase   <= '0;
            r_samp    <= 2'b11;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_ready   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_sync1 <= RxD;
            r_sync2 <= r_sync1;
            r_ready <= w_ready_nxt;
            r_error <= w_error_nxt;

            if (r_state == IDLE) begin
                r_phase   <= '0;
                r_bit_idx <= '0;
            end else if (w_tick) begin
                r_phase <= r_phase + PH_W'(1);
            end

            if (w_tick && (r_phase == PH_S0)) r_samp[0] <= w_rx;
            if (w_tick && (r_phase == PH_S1)) r_samp[1] <= w_rx;

            if ((r_state == DATA) && w_vote_tick) r_shift   <= {w_vote, r_shift[7:1]};
            if ((r_state == DATA) && w_wrap)      r_bit_idx <= r_bit_idx + 3'd1;

            if (w_ready_nxt) r_data <= r_shift;
        end
    end

    assign RxD_data       = r_data;
    assign RxD_data_ready = r_ready;
    assign RxD_data_error = r_error;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// tb/tb_uart_byte_receiver.sv - self-checking bench for uart_byte_receiver
module tb_uart_byte_receiver;

    localparam int CLK_FREQ = 64_000_000;
    localparam int BAUD     = 1_000_000;
    localparam int OS       = 16;
    localparam int DIV      = 4;
    localparam int BIT      = DIV * OS;
    localparam int LAT_MIN  = (BIT * 19) / 2 - 6;
    localparam int LAT_MAX  = (BIT * 19) / 2 + 24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RxD = 1'b1;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_data_error;

    always #5 clk = ~clk;

    uart_byte_receiver #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .RxD            (RxD),
        .RxD_data       (RxD_data),
        .RxD_data_ready (RxD_data_ready),
        .RxD_data_error (RxD_data_error)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         start_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          n_ready = 0;
    int          n_error = 0;
    logic [7:0]  model_data = 8'h00;
    logic [31:0] word = 32'h0;
    logic        prev_ready = 1'b0;
    logic        prev_error = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic check_true(input string name, input bit ok, input logic [31:0] act);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0h condition not met (t=%0t)", name, act, $time);
        end
    endtask

    // Every output cycle is checked against the queue of expected frame outcomes.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_data = 8'h00;
            prev_ready = 1'b0;
            prev_error = 1'b0;
        end else begin
            exp_t e;
            check_true("exclusive", !(RxD_data_ready && RxD_data_error),
                       {30'd0, RxD_data_ready, RxD_data_error});
            if (RxD_data_ready) begin
                n_ready++;
                check_true("ready_width", !prev_ready, 32'd2);
                check_true("ready_expected", exp_q.size() > 0 && !exp_q[0].is_err, exp_q.size());
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("ready_data", RxD_data, e.data);
                    check_true("ready_latency",
                               (cyc - e.start_cyc) >= LAT_MIN && (cyc - e.start_cyc) <= LAT_MAX,
                               cyc - e.start_cyc);
                    model_data = e.data;
                end
                word = {RxD_data, word[31:8]};
            end else if (RxD_data_error) begin
                n_error++;
                check_true("error_width", !prev_error, 32'd2);
                check_true("error_expected", exp_q.size() > 0 && exp_q[0].is_err, exp_q.size());
                if (exp_q.size() > 0) e = exp_q.pop_front();
                check_eq("error_data_hold", RxD_data, model_data);
            end else begin
                check_eq("data_hold", RxD_data, model_data);
            end
            prev_ready = RxD_data_ready;
            prev_error = RxD_data_error;
        end
    end

    task automatic drive_bit(input logic v);
        RxD = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap_bits);
        exp_t e;
        check_eq("missing_event", exp_q.size(), 0);
        e.is_err    = !stop_ok;
        e.data      = b;
        e.start_cyc = cyc;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        for (int i = 0; i < gap_bits; i++) drive_bit(1'b1);
    endtask

    initial begin
        logic [7:0] rb;
        bit         rok;
        int         rgap;
        logic [7:0] abort_byte;

        rst_n = 1'b0;
        RxD   = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("reset_data", RxD_data, 8'h00);
        check_eq("reset_ready", RxD_data_ready, 0);
        check_eq("reset_error", RxD_data_error, 0);
        rst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);

        send_frame(8'hA5, 1'b1, 2);
        check_eq("a5_data", RxD_data, 8'hA5);
        check_eq("a5_ready_count", n_ready, 1);
        check_eq("a5_error_count", n_error, 0);

        send_frame(8'h01, 1'b1, 0);
        send_frame(8'h23, 1'b1, 0);
        send_frame(8'h45, 1'b1, 0);
        send_frame(8'h67, 1'b1, 2);
        check_eq("b2b_word", word, 32'h67452301);
        check_eq("b2b_ready_count", n_ready, 5);

        send_frame(8'h3C, 1'b0, 2);
        check_eq("ferr_error_count", n_error, 1);
        check_eq("ferr_ready_count", n_ready, 5);
        check_eq("ferr_data_hold", RxD_data, 8'h67);

        send_frame(8'h5A, 1'b1, 2);
        check_eq("after_ferr_data", RxD_data, 8'h5A);
        check_eq("after_ferr_ready_count", n_ready, 6);

        // Start glitch shorter than half a bit.
        check_eq("missing_event", exp_q.size(), 0);
        RxD = 1'b0;
        repeat ((OS / 4) * DIV) @(negedge clk);
        RxD = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        check_eq("glitch_ready_count", n_ready, 6);
        check_eq("glitch_error_count", n_error, 1);
        check_eq("glitch_data", RxD_data, 8'h5A);

        // Reset asserted during data bit 4; the partial byte is discarded.
        check_eq("missing_event", exp_q.size(), 0);
        abort_byte = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(abort_byte[i]);
        RxD = abort_byte[4];
        repeat (BIT / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        RxD = 1'b1;
        check_eq("midreset_data", RxD_data, 8'h00);
        check_eq("midreset_ready", RxD_data_ready, 0);
        rst_n = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        check_eq("post_reset_ready_count", n_ready, 6);
        send_frame(8'hFF, 1'b1, 2);
        check_eq("ff_data", RxD_data, 8'hFF);
        check_eq("ff_ready_count", n_ready, 7);

        for (int k = 0; k < 30; k++) begin
            rb   = 8'($urandom);
            rok  = ($urandom_range(0, 9) != 0);
            rgap = rok ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3));
            send_frame(rb, rok, rgap);
        end
        drive_bit(1'b1);
        drive_bit(1'b1);
        check_eq("missing_event_final", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
